// File: rtl/gray_binary_seq.sv
// gray_binary_seq: sequential Gray-to-binary decoder, one bit per clock, MSB first.
// A Gray word is accepted over a valid/ready handshake. It is resolved over W
// cycles and then held on b with out_valid until the consumer takes it.
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   in_valid/ready   input handshake; in_ready is decoded from state only
//   g[0:W-1]         Gray word, index 0 = MSB, sampled only at the accept edge
//   out_valid/ready  output handshake; b and out_valid hold until out_ready
//   b[0:W-1]         binary word, index 0 = MSB
//   busy             high while the conversion is in progress
module gray_binary_seq #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:W-1] g,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] b,
    output logic         busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [0:W-1]  r_gq;
    logic [0:W-1]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_par;
    logic          r_out_valid;
    logic          w_bit;

    // r_par carries the previously resolved binary bit (0 before the MSB),
    // so every bit is a single XOR with no index arithmetic on r_b.
    assign w_bit = r_par ^ r_gq[r_cnt];

    // Control FSM with registered datapath and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gq        <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_gq    <= g;
                        r_b     <= '0;
                        r_cnt   <= '0;
                        r_par   <= 1'b0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_b[r_cnt] <= w_bit;
                    r_par      <= w_bit;
                    if (r_cnt == LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from the state register only; never depends on in_valid.
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == CONV);
    assign out_valid = r_out_valid;
    assign b         = r_b;

endmodule

// File: tb/tb_gray_binary_seq.sv
// tb_gray_binary_seq: drives W=4, W=8 and W=1 instances of gray_binary_seq and
// checks every cycle against a transaction-level model (accept time + value).
module tb_gray_binary_seq;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv   [NI];
    logic       ordy [NI];
    logic [7:0] gv   [NI];
    logic       ir   [NI];
    logic       ov   [NI];
    logic       bz   [NI];
    logic [7:0] bv   [NI];

    logic       ir0, ov0, bz0, ir1, ov1, bz1, ir2, ov2, bz2;
    logic [3:0] b4;
    logic [7:0] b8;
    logic [0:0] b1;

    gray_binary_seq #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .g(gv[0][3:0]),
        .out_valid(ov0), .out_ready(ordy[0]), .b(b4), .busy(bz0));
    gray_binary_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .g(gv[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .b(b8), .busy(bz1));
    gray_binary_seq #(.W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .g(gv[2][0:0]),
        .out_valid(ov2), .out_ready(ordy[2]), .b(b1), .busy(bz2));

    assign ir[0] = ir0; assign ov[0] = ov0; assign bz[0] = bz0; assign bv[0] = {4'd0, b4};
    assign ir[1] = ir1; assign ov[1] = ov1; assign bz[1] = bz1; assign bv[1] = b8;
    assign ir[2] = ir2; assign ov[2] = ov2; assign bz[2] = bz2; assign bv[2] = {7'd0, b1};

    function automatic int wd(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Transaction model: a word is pending from its accept edge until the
    // output handshake; everything else follows from edges elapsed since accept.
    int unsigned ecount = 0;
    bit          pend  [NI];
    int unsigned tacc  [NI];
    logic [7:0]  mx    [NI];
    logic [7:0]  cur_x [NI];
    int          mres  [NI];
    int          dres  [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) pend[i] = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (!pend[i]) begin
                    if (iv[i]) begin
                        pend[i] = 1'b1;
                        tacc[i] = ecount + 1;
                        mx[i]   = cur_x[i];
                    end
                end else if ((ecount - tacc[i]) >= wd(i) && ordy[i]) begin
                    pend[i] = 1'b0;
                    mres[i]++;
                end
            end
            ecount++;
        end
    end

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin : cmp
                int unsigned k;
                int unsigned kk;
                int unsigned w;
                int unsigned m;
                w = wd(i);
                k = ecount - tacc[i];
                chk("in_ready", i, ir[i], !pend[i]);
                chk("busy", i, bz[i], pend[i] && (k < w));
                chk("out_valid", i, ov[i], pend[i] && (k >= w));
                if (pend[i]) begin
                    // Top kk bits resolved, the rest still zero.
                    kk = (k < w) ? k : w;
                    m  = ((32'd1 << kk) - 32'd1) << (w - kk);
                    chk("b", i, bv[i], mx[i] & m[7:0]);
                end
                if (ov[i] && ordy[i]) dres[i]++;
            end
        end
    end

    // One word: present, wait for accept, then run the output handshake.
    // mode 0: out_ready always 1; 1: random; 2: held low for 'hold' valid cycles.
    // inj >= 0 drives in_valid with that Gray value during the conversion.
    task automatic send(input int i, input logic [7:0] gw, input logic [7:0] x,
                        input int mode, input int hold, input int inj,
                        output int unsigned acc_e);
        int  n;
        int  hl;
        bit  ok;
        bit  done;
        cur_x[i] = x;
        gv[i]    = gw;
        iv[i]    = 1'b1;
        ordy[i]  = (mode == 0);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            ok = ir[i];
            @(posedge clk); #1;
            n++;
        end
        acc_e = ecount;
        chk("accept", i, ok, 1);
        iv[i] = 1'b0;
        if (!ok) return;
        hl   = hold;
        done = 1'b0;
        n    = 0;
        while (!done) begin
            if (ov[i]) begin
                iv[i] = 1'b0;
                if (mode == 2 && hl > 0) begin
                    ordy[i] = 1'b0;
                    hl--;
                    chk("held_b", i, bv[i], x);
                end else if (mode == 1) begin
                    ordy[i] = 1'($urandom_range(0, 1));
                end else begin
                    ordy[i] = 1'b1;
                end
                if (ordy[i]) chk("result", i, bv[i], x);
                done = ordy[i];
            end else begin
                ordy[i] = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
                if (inj >= 0) begin
                    iv[i] = 1'b1;
                    gv[i] = 8'(inj);
                end else begin
                    gv[i] = 8'($urandom);
                end
            end
            @(posedge clk); #1;
            n++;
            if (!done && n >= 400) begin
                chk("handshake_timeout", i, 0, 1);
                done = 1'b1;
            end
        end
        iv[i] = 1'b0;
    endtask

    // Back-to-back round trip of n words; checks the W+2 period after any
    // word whose result was taken on its first valid cycle.
    task automatic run_all(input int i, input int nw);
        int unsigned acc;
        int unsigned prev_acc;
        bit          prev_imm;
        int          mode;
        int          inj;
        logic [7:0]  x;
        prev_imm = 1'b0;
        prev_acc = 0;
        for (int n = 0; n < nw; n++) begin
            x    = 8'(n % (1 << wd(i)));
            mode = ($urandom_range(0, 2) == 0) ? 0 : 1;
            inj  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            send(i, x ^ (x >> 1), x, mode, 0, inj, acc);
            if (prev_imm) chk("period", i, acc - prev_acc, wd(i) + 2);
            prev_imm = (mode == 0);
            prev_acc = acc;
        end
    endtask

    int unsigned acc_tmp;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; gv[i] = 8'd0; cur_x[i] = 8'd0;
            mres[i] = 0; dres[i] = 0; tacc[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_in_ready", i, ir[i], 1);
            chk("rst_out_valid", i, ov[i], 0);
            chk("rst_busy", i, bz[i], 0);
            chk("rst_b", i, bv[i], 0);
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed W=4 words with hand-derived results.
        send(0, 8'h6, 8'h4, 0, 0, -1, acc_tmp);
        send(0, 8'h8, 8'hF, 0, 0, -1, acc_tmp);
        send(0, 8'hD, 8'h9, 2, 10, -1, acc_tmp);
        send(0, 8'h3, 8'h2, 0, 0, 1, acc_tmp);
        repeat (8) @(posedge clk);
        #1;

        // W=1 words.
        send(2, 8'h1, 8'h1, 0, 0, -1, acc_tmp);
        send(2, 8'h0, 8'h0, 0, 0, -1, acc_tmp);

        // Reset in the middle of a conversion clears outputs without a clock.
        cur_x[0] = 8'h2;
        gv[0]    = 8'h3;
        iv[0]    = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #3;
        chk("pre_rst_busy", 0, bz[0], 1);
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 0, ir[0], 1);
        chk("async_out_valid", 0, ov[0], 0);
        chk("async_busy", 0, bz[0], 0);
        chk("async_b", 0, bv[0], 0);
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Exhaustive round trips on all three widths in parallel.
        fork
            run_all(0, 16);
            run_all(1, 256);
            run_all(2, 8);
        join
        repeat (12) @(posedge clk);
        #1;

        chk("results_dut", 0, dres[0], 20);
        chk("results_dut", 1, dres[1], 256);
        chk("results_dut", 2, dres[2], 10);
        chk("results_model", 0, mres[0], 20);
        chk("results_model", 1, mres[1], 256);
        chk("results_model", 2, mres[2], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
